// File: rtl/gf_mult_arbiter_if.sv
// Requester/response bundle for the shared GF(2^3) multiplier arbiter.
interface gf_mult_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) ();
    logic [NREQ-1:0]   req_valid;
    logic [3*NREQ-1:0] req_a;
    logic [3*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [2:0]        rsp_z;
    logic              rsp_ready;
    logic              busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_z, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_z, busy
    );
endinterface

// File: rtl/gf_mult_arbiter.sv
// Round-robin arbiter feeding a two-stage pipeline around one GF(2^3) multiplier
// (field polynomial x^3 + x + 1); results return in acceptance order.
module gf_mult_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input logic              clk,
    input logic              reset,
    gf_mult_arbiter_if.slave bus
);
    localparam int unsigned OPW = 3;

    function automatic logic [OPW-1:0] gf_mult(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        logic [OPW-1:0] acc;
        logic [OPW-1:0] x;
        acc = '0;
        x   = a;
        for (int unsigned i = 0; i < OPW; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x[OPW-1] ? ({x[OPW-2:0], 1'b0} ^ 3'b011) : {x[OPW-2:0], 1'b0};
        end
        return acc;
    endfunction

    logic             r_op_valid;
    logic [OPW-1:0]   r_op_a;
    logic [OPW-1:0]   r_op_b;
    logic [IDW-1:0]   r_op_id;
    logic [IDW-1:0]   r_ptr;
    logic             r_rsp_valid;
    logic [OPW-1:0]   r_rsp_z;
    logic [IDW-1:0]   r_rsp_id;

    logic [OPW-1:0]   w_a [NREQ];
    logic [OPW-1:0]   w_b [NREQ];
    logic [OPW-1:0]   w_prod;
    logic             w_rsp_adv;
    logic             w_op_free;
    logic             w_found;
    logic [IDW-1:0]   w_grant;
    logic [IDW-1:0]   w_cand;
    logic [31:0]      w_scan;
    logic [NREQ-1:0]  w_req_ready;
    logic             w_accept;
    logic [IDW-1:0]   w_ptr_nxt;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_a[g] = bus.req_a[OPW*g +: OPW];
        assign w_b[g] = bus.req_b[OPW*g +: OPW];
    end

    assign w_prod    = gf_mult(r_op_a, r_op_b);
    assign w_rsp_adv = r_op_valid && (!r_rsp_valid || bus.rsp_ready);
    assign w_op_free = !r_op_valid || w_rsp_adv;

    // First valid requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_cand  = '0;
        w_scan  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_scan = (32'(r_ptr) + k) % NREQ;
            w_cand = IDW'(w_scan);
            if (!w_found && bus.req_valid[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
    end

    always_comb begin
        w_req_ready = '0;
        if (w_op_free && w_found && !reset) w_req_ready[w_grant] = 1'b1;
    end

    assign w_accept  = |w_req_ready;
    assign w_ptr_nxt = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + IDW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_valid  <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_id     <= '0;
            r_ptr       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_z     <= '0;
            r_rsp_id    <= '0;
        end else begin
            if (w_rsp_adv) begin
                r_rsp_valid <= 1'b1;
                r_rsp_z     <= w_prod;
                r_rsp_id    <= r_op_id;
            end else if (r_rsp_valid && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end

            if (w_accept) begin
                r_op_valid <= 1'b1;
                r_op_a     <= w_a[w_grant];
                r_op_b     <= w_b[w_grant];
                r_op_id    <= w_grant;
                r_ptr      <= w_ptr_nxt;
            end else if (w_op_free) begin
                r_op_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_z     = r_rsp_z;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.busy      = r_op_valid || r_rsp_valid;
endmodule

// File: tb/tb_gf_mult_arbiter.sv
// Randomized self-checking bench: a FIFO-of-results reference model predicts grants,
// response timing and products for gf_mult_arbiter.
module tb_gf_mult_arbiter;
    localparam int unsigned NREQ = 4;

    typedef struct {
        int id;
        int z;
        int age;
    } item_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    gf_mult_arbiter_if #(.NREQ(NREQ)) bus ();

    gf_mult_arbiter #(.NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [NREQ-1:0] s_valid;
    logic [2:0]      s_a [NREQ];
    logic [2:0]      s_b [NREQ];
    logic            s_rsp_ready;

    item_t q[$];
    int    m_ptr;
    int    gq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Carry-less product, then reduction by x^3 + x + 1.
    function automatic int gf_ref(input int a, input int b);
        int p;
        p = 0;
        for (int i = 0; i < 3; i++)
            if (((b >> i) & 1) == 1) p = p ^ (a << i);
        for (int d = 4; d >= 3; d--)
            if (((p >> d) & 1) == 1) p = p ^ (11 << (d - 3));
        return p;
    endfunction

    task automatic drive();
        bus.req_valid = s_valid;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[3*i +: 3] = s_a[i];
            bus.req_b[3*i +: 3] = s_b[i];
        end
        bus.rsp_ready = s_rsp_ready;
    endtask

    task automatic refill(input logic [NREQ-1:0] mask);
        for (int i = 0; i < NREQ; i++) begin
            if (mask[i] && !s_valid[i]) begin
                s_valid[i] = 1'b1;
                s_a[i] = 3'($urandom_range(0, 7));
                s_b[i] = 3'($urandom_range(0, 7));
            end
        end
    endtask

    // One cycle: drive at the falling edge, check, advance the model over the rising edge.
    task automatic step();
        logic [NREQ-1:0] exp_rdy;
        bit ev;
        int g;
        item_t it;
        drive();
        #1;
        ev = (q.size() > 0) && (q[0].age >= 2);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
        if (ev) begin
            chk("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
            chk("rsp_z", 32'(bus.rsp_z), 32'(q[0].z));
        end
        chk("busy", 32'(bus.busy), 32'(q.size() > 0));
        g = -1;
        if (q.size() < 2 || s_rsp_ready) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (g < 0 && s_valid[j]) g = j;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        for (int k = 0; k < NREQ; k++)
            if (bus.req_ready[k]) gq.push_back(k);
        if (ev && s_rsp_ready) void'(q.pop_front());
        if (g >= 0) begin
            it.id  = g;
            it.z   = gf_ref(int'(s_a[g]), int'(s_b[g]));
            it.age = 0;
            q.push_back(it);
            m_ptr = (g + 1) % NREQ;
            s_valid[g] = 1'b0;
        end
        foreach (q[i]) q[i].age++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req_valid = '1;
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 0);
        chk("rst_rsp_z", 32'(bus.rsp_z), 0);
        q.delete();
        m_ptr = 0;
        s_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain(input int n);
        s_valid = '0;
        s_rsp_ready = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        int exp_order[4];
        int n;
        s_valid = '0;
        s_rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            s_a[i] = '0;
            s_b[i] = '0;
        end
        m_ptr = 0;
        drive();
        #2;
        do_reset();

        // Single request from requester 2, A=5, B=0.
        s_valid[2] = 1'b1;
        s_a[2] = 3'd5;
        s_b[2] = 3'd0;
        step();
        drain(4);

        // All requesters streaming: grants 0,1,2,3,0,...
        do_reset();
        gq.delete();
        repeat (12) begin
            refill(4'b1111);
            step();
        end
        chk("rr_cnt", 32'(gq.size()), 12);
        for (int i = 0; i < gq.size() && i < 12; i++) chk("rr_order", 32'(gq[i]), 32'(i % 4));
        drain(4);

        // Requesters 1 and 3 only, starting with ptr=2.
        do_reset();
        s_valid[1] = 1'b1;
        step();
        drain(3);
        gq.delete();
        repeat (4) begin
            refill(4'b1010);
            step();
        end
        exp_order = '{3, 1, 3, 1};
        chk("odd_cnt", 32'(gq.size()), 4);
        for (int i = 0; i < gq.size() && i < 4; i++) chk("odd_order", 32'(gq[i]), 32'(exp_order[i]));
        drain(4);

        // Backpressure: both stages full, consumer stalled for 5 cycles.
        s_rsp_ready = 1'b0;
        refill(4'b0011);
        step();
        step();
        refill(4'b0100);
        repeat (5) step();
        s_rsp_ready = 1'b1;
        drain(6);

        // Exhaustive operand sweep on requester 0 with random backpressure.
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                s_valid[0] = 1'b1;
                s_a[0] = 3'(a);
                s_b[0] = 3'(b);
                n = 0;
                while (s_valid[0] && n < 20) begin
                    s_rsp_ready = ($urandom_range(0, 3) != 0);
                    step();
                    n++;
                end
                if (s_valid[0]) begin
                    chk("sweep_timeout", 0, 1);
                    s_valid[0] = 1'b0;
                end
            end
        end
        drain(4);

        // Random traffic.
        repeat (300) begin
            for (int i = 0; i < NREQ; i++)
                if (!s_valid[i] && $urandom_range(0, 1) == 1) refill(4'(1 << i));
            s_rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain(4);

        // Asynchronous reset with both stages full.
        s_rsp_ready = 1'b0;
        refill(4'b0110);
        step();
        step();
        chk("full_busy", 32'(bus.busy), 1);
        #3;
        do_reset();
        s_rsp_ready = 1'b1;
        gq.delete();
        refill(4'b1111);
        step();
        chk("post_rst_grant", (gq.size() > 0) ? 32'(gq[0]) : 32'd99, 0);
        drain(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
